// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_op_sequencer_if : request / ALU / response bundle for the sequencer  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface alu_op_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [7:0]       req_a;
  logic [7:0]       req_b;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [2:0]       alu_mode;
  logic             alu_ee;
  logic             alu_eo;
  logic [7:0]       alu_bus;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic             rsp_zero;
  logic             rsp_carry;
  logic [CNT_W-1:0] op_count;

  // master: the sequencer itself; slave: decoder, ALU and result consumer
  modport master (
    input  req_valid, req_op, req_a, req_b, alu_bus, alu_carry, rsp_ready,
    output req_ready, alu_a, alu_b, alu_mode, alu_ee, alu_eo,
           rsp_valid, rsp_data, rsp_zero, rsp_carry, op_count
  );
  modport slave (
    output req_valid, req_op, req_a, req_b, alu_bus, alu_carry, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_mode, alu_ee, alu_eo,
           rsp_valid, rsp_data, rsp_zero, rsp_carry, op_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_op_sequencer : queued request -> ALU EXEC/READ sequencing -> response|
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module alu_op_sequencer #(
  parameter int QDEPTH = 2,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.master bus
);
  localparam int               c_PTR_W = $clog2(QDEPTH);
  localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W+1)'(QDEPTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EXEC = 2'd1;
  localparam logic [1:0] c_READ = 2'd2;
  localparam logic [1:0] c_RESP = 2'd3;

  logic [1:0]         r_state;
  logic [2:0]         r_q_op [QDEPTH];
  logic [7:0]         r_q_a  [QDEPTH];
  logic [7:0]         r_q_b  [QDEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W:0]   r_count;
  logic [7:0]         r_alu_a;
  logic [7:0]         r_alu_b;
  logic [2:0]         r_alu_mode;
  logic [7:0]         r_rsp_data;
  logic               r_rsp_zero;
  logic               r_rsp_carry;
  logic [CNT_W-1:0]   r_op_count;

  logic w_req_ready;
  logic w_push;
  logic w_pop;
  logic w_rsp_hs;
  logic w_nonempty;

  assign w_nonempty  = (r_count != '0);
  assign w_req_ready = (r_count < c_FULL);
  assign w_push      = bus.req_valid && w_req_ready;
  assign w_rsp_hs    = (r_state == c_RESP) && bus.rsp_ready;
  // Pops only at the IDLE check or when a response leaves, never mid-operation
  assign w_pop       = w_nonempty && ((r_state == c_IDLE) || w_rsp_hs);

  // Queue storage carries no reset; validity is tracked by r_count alone
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_op[r_wptr] <= bus.req_op;
      r_q_a[r_wptr]  <= bus.req_a;
      r_q_b[r_wptr]  <= bus.req_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_mode  <= '0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (w_pop) begin
        r_alu_a    <= r_q_a[r_rptr];
        r_alu_b    <= r_q_b[r_rptr];
        r_alu_mode <= r_q_op[r_rptr];
      end
      case (r_state)
        c_IDLE: if (w_pop) r_state <= c_EXEC;
        c_EXEC: r_state <= c_READ;
        c_READ: begin
          r_rsp_data  <= bus.alu_bus;
          r_rsp_zero  <= (bus.alu_bus == 8'h00);
          // Only add/adc/sub produce a meaningful carry
          r_rsp_carry <= (r_alu_mode <= 3'd2) ? bus.alu_carry : 1'b0;
          r_state     <= c_RESP;
        end
        c_RESP: begin
          if (bus.rsp_ready) begin
            r_op_count <= r_op_count + CNT_W'(1);
            r_state    <= w_pop ? c_EXEC : c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_mode  = r_alu_mode;
  assign bus.alu_ee    = (r_state == c_EXEC);
  assign bus.alu_eo    = (r_state == c_READ);
  assign bus.rsp_valid = (r_state == c_RESP);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_zero  = r_rsp_zero;
  assign bus.rsp_carry = r_rsp_carry;
  assign bus.op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// Scoreboarded bench for alu_op_sequencer (QDEPTH=2, CNT_W=2) with a
// behavioural ALU that drives a filler byte on the bus when not enabled.
module tb_alu_op_sequencer;
  logic clk;
  logic rst_n;

  alu_op_sequencer_if #(.CNT_W(2)) bus ();

  alu_op_sequencer #(.QDEPTH(2), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: bit 8 is carry/borrow; logic ops leave a stale carry of 1
  logic [8:0] w_res;
  always_comb begin
    w_res = 9'h000;
    case (bus.alu_mode)
      3'd0: w_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'd1: w_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 9'd1;
      3'd2: w_res = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'd3: w_res = {1'b1, bus.alu_a + 8'd1};
      3'd4: w_res = {1'b1, bus.alu_a - 8'd1};
      3'd5: w_res = {1'b1, bus.alu_a & bus.alu_b};
      3'd6: w_res = {1'b1, bus.alu_a | bus.alu_b};
      default: w_res = {1'b1, bus.alu_a ^ bus.alu_b};
    endcase
  end
  assign bus.alu_bus   = bus.alu_eo ? w_res[7:0] : 8'hA5;
  assign bus.alu_carry = w_res[8];

  typedef struct {
    logic [7:0] d;
    logic       z;
    logic       c;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  logic [1:0] exp_cnt = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] d, input logic z, input logic c, input int gap);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    #1;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 40) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 40 cycles");
    end
    e.d = d; e.z = z; e.c = c; e.gap = gap;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic stop_req();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every handshake pops one expectation, then checks the counter
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got data %0h expected no response", bus.rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data",  bus.rsp_data,  e.d);
          chk("rsp_zero",  bus.rsp_zero,  e.z);
          chk("rsp_carry", bus.rsp_carry, e.c);
          if (e.gap != 0) chk("rsp_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
        exp_cnt  = exp_cnt + 2'd1;
        @(negedge clk);
        #1;
        chk("op_count", bus.op_count, exp_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    bus.rsp_ready = 1'b1;
    #12;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_ee_eo",     {bus.alu_ee, bus.alu_eo}, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_operands",  {bus.alu_a, bus.alu_b, bus.alu_mode}, 0);
    chk("rst_rsp_regs",  {bus.rsp_data, bus.rsp_zero, bus.rsp_carry}, 0);
    chk("rst_op_count",  bus.op_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add from empty queue, with phase-by-phase timing checks
    send(3'd0, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 0);
    stop_req();
    #1;
    chk("t0_ee_eo", {bus.alu_ee, bus.alu_eo}, 2'b00);
    @(negedge clk); #1;
    chk("t1_ee_eo",    {bus.alu_ee, bus.alu_eo}, 2'b10);
    chk("t1_operands", {bus.alu_a, bus.alu_b, bus.alu_mode}, {8'hF0, 8'h20, 3'd0});
    @(negedge clk); #1;
    chk("t2_ee_eo", {bus.alu_ee, bus.alu_eo}, 2'b01);
    @(negedge clk); #1;
    chk("t3_rsp_valid", bus.rsp_valid, 1);
    drain();

    // Zero results; inc must force carry low despite the ALU's carry
    send(3'd2, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 0);
    send(3'd3, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 0);
    stop_req();
    drain();

    // Queue full: four back-to-back requests
    send(3'd6, 8'h30, 8'h03, 8'h33, 1'b0, 1'b0, 0);
    send(3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 3);
    send(3'd4, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 3);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("full_req_ready", bus.req_ready, 0);
    send(3'd1, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 3);
    stop_req();
    drain();

    // Response stall with a second request queued
    bus.rsp_ready = 1'b0;
    send(3'd2, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 0);
    send(3'd1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 0);
    stop_req();
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("stall_rsp_valid", bus.rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("stall_rsp_hold", {bus.rsp_data, bus.rsp_zero, bus.rsp_carry, bus.rsp_valid},
          {8'hFE, 1'b0, 1'b1, 1'b1});
      chk("stall_no_pulse", {bus.alu_ee, bus.alu_eo}, 2'b00);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("release_ee", bus.alu_ee, 1);
    drain();

    // Reset while the execute strobe is high
    send(3'd0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 0);
    stop_req();
    n = 0;
    while (!bus.alu_ee && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("pre_rst_ee", bus.alu_ee, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ee",        bus.alu_ee, 0);
    chk("async_rst_rsp_valid", bus.rsp_valid, 0);
    chk("async_rst_op_count",  bus.op_count, 0);
    chk("async_rst_req_ready", bus.req_ready, 1);
    exp_q.delete();
    exp_cnt = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_rst_idle", {bus.alu_ee, bus.alu_eo, bus.rsp_valid}, 3'b000);
    end

    // Fresh traffic after reset; op_count walks 1,2,3,0,1,2
    send(3'd5, 8'hCC, 8'h0F, 8'h0C, 1'b0, 1'b0, 0);
    send(3'd6, 8'h30, 8'h03, 8'h33, 1'b0, 1'b0, 3);
    send(3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 3);
    send(3'd3, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 3);
    send(3'd4, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 3);
    send(3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 3);
    stop_req();
    drain();
    chk("final_op_count", bus.op_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
